// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe
// Brief    : Multi-channel MEM->WB pipeline register with per-channel valid,
//            stall hold, bubble insertion, flush, same-bundle write-conflict
//            resolution (youngest writer wins) and a retired-instruction counter.
//            Optional macro MEM_WB_DEBUG_PC_EN adds the mem_pc/wb_pc debug path.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_pipe #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 32,
    parameter int ZERO_SUPP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        mem_valid,
    input  logic [NUM_CH-1:0]        mem_we,
    input  logic [NUM_CH*ADDR_W-1:0] mem_waddr,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
`ifdef MEM_WB_DEBUG_PC_EN
    input  logic [NUM_CH*32-1:0]     mem_pc,
    output logic [NUM_CH*32-1:0]     wb_pc,
`endif
    output logic [NUM_CH-1:0]        wb_valid,
    output logic [NUM_CH-1:0]        wb_we,
    output logic [NUM_CH*ADDR_W-1:0] wb_waddr,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam logic [1:0] c_MODE_CAPTURE = 2'd0;
    localparam logic [1:0] c_MODE_BUBBLE  = 2'd1;
    localparam logic [1:0] c_MODE_HOLD    = 2'd2;

    logic [1:0]               w_mode;
    logic [NUM_CH-1:0]        w_zero_hit;
    logic [NUM_CH-1:0]        w_shadow;
    logic [CNT_W-1:0]         w_pop;

    logic [NUM_CH-1:0]        wb_valid_d,   wb_valid_q;
    logic [NUM_CH-1:0]        wb_we_d,      wb_we_q;
    logic [NUM_CH*ADDR_W-1:0] wb_waddr_d,   wb_waddr_q;
    logic [NUM_CH*DATA_W-1:0] wb_wdata_d,   wb_wdata_q;
    logic [CNT_W-1:0]         retire_cnt_d, retire_cnt_q;

    // Flush outranks every stall combination; stall[5] alone is a capture.
    always_comb begin
        w_mode = c_MODE_CAPTURE;
        if (flush) begin
            w_mode = c_MODE_BUBBLE;
        end else if (stall[4] && !stall[5]) begin
            w_mode = c_MODE_BUBBLE;
        end else if (stall[4] && stall[5]) begin
            w_mode = c_MODE_HOLD;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_zero
            assign w_zero_hit[gi] = (ZERO_SUPP != 0) &&
                                    (mem_waddr[gi*ADDR_W +: ADDR_W] == '0);
        end
    endgenerate

    // An older channel is shadowed by any younger valid writer to the same register.
    always_comb begin
        w_shadow = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = i + 1; j < NUM_CH; j++) begin
                if (mem_valid[j] && mem_we[j] &&
                    (mem_waddr[j*ADDR_W +: ADDR_W] == mem_waddr[i*ADDR_W +: ADDR_W])) begin
                    w_shadow[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop = w_pop + CNT_W'(mem_valid[i]);
        end
    end

    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_we_d      = wb_we_q;
        wb_waddr_d   = wb_waddr_q;
        wb_wdata_d   = wb_wdata_q;
        retire_cnt_d = retire_cnt_q;
        case (w_mode)
            c_MODE_BUBBLE: begin
                wb_valid_d = '0;
                wb_we_d    = '0;
                wb_waddr_d = '0;
                wb_wdata_d = '0;
            end
            c_MODE_HOLD: begin
            end
            default: begin
                wb_valid_d   = mem_valid;
                wb_we_d      = mem_valid & mem_we & ~w_zero_hit & ~w_shadow;
                wb_waddr_d   = mem_waddr;
                wb_wdata_d   = mem_wdata;
                retire_cnt_d = retire_cnt_q + w_pop;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q   <= '0;
            wb_we_q      <= '0;
            wb_waddr_q   <= '0;
            wb_wdata_q   <= '0;
            retire_cnt_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_wdata_q   <= wb_wdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

`ifdef MEM_WB_DEBUG_PC_EN
    logic [NUM_CH*32-1:0] wb_pc_d, wb_pc_q;

    always_comb begin
        wb_pc_d = wb_pc_q;
        case (w_mode)
            c_MODE_BUBBLE: wb_pc_d = '0;
            c_MODE_HOLD:   wb_pc_d = wb_pc_q;
            default:       wb_pc_d = mem_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_pc_q <= '0;
        end else begin
            wb_pc_q <= wb_pc_d;
        end
    end

    assign wb_pc = wb_pc_q;
`endif

    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_waddr   = wb_waddr_q;
    assign wb_wdata   = wb_wdata_q;
    assign retire_cnt = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_pipe
// Brief    : Table-driven scoreboard bench for mem_wb_pipe (NUM_CH=2, CNT_W=4
//            so the counter wrap is reachable), plus async-reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_pipe;

    localparam int c_NUM_CH = 2;
    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;
    localparam int c_CNT_W  = 4;

    logic                         clk;
    logic                         rst;
    logic [5:0]                   stall;
    logic                         flush;
    logic [c_NUM_CH-1:0]          mem_valid;
    logic [c_NUM_CH-1:0]          mem_we;
    logic [c_NUM_CH*c_ADDR_W-1:0] mem_waddr;
    logic [c_NUM_CH*c_DATA_W-1:0] mem_wdata;
    logic [c_NUM_CH-1:0]          wb_valid;
    logic [c_NUM_CH-1:0]          wb_we;
    logic [c_NUM_CH*c_ADDR_W-1:0] wb_waddr;
    logic [c_NUM_CH*c_DATA_W-1:0] wb_wdata;
    logic [c_CNT_W-1:0]           retire_cnt;
`ifdef MEM_WB_DEBUG_PC_EN
    logic [c_NUM_CH*32-1:0]       mem_pc;
    logic [c_NUM_CH*32-1:0]       wb_pc;
`endif

    mem_wb_pipe #(
        .NUM_CH    (c_NUM_CH),
        .DATA_W    (c_DATA_W),
        .ADDR_W    (c_ADDR_W),
        .CNT_W     (c_CNT_W),
        .ZERO_SUPP (1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
`ifdef MEM_WB_DEBUG_PC_EN
        .mem_pc     (mem_pc),
        .wb_pc      (wb_pc),
`endif
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  st;
        logic        fl;
        logic [1:0]  v;
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  ev;
        logic [1:0]  ewe;
        logic [4:0]  ea0;
        logic [4:0]  ea1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [3:0]  ecnt;
    } vec_t;

    int   checks;
    int   errors;
    vec_t tbl[19];
    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic [5:0] st, input logic fl, input logic [1:0] v, input logic [1:0] we,
        input logic [4:0] a0, input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1,
        input logic [1:0] ev, input logic [1:0] ewe, input logic [4:0] ea0, input logic [4:0] ea1,
        input logic [31:0] ed0, input logic [31:0] ed1, input logic [3:0] ecnt);
        vec_t r;
        r.st = st;  r.fl = fl;   r.v = v;     r.we = we;
        r.a0 = a0;  r.a1 = a1;   r.d0 = d0;   r.d1 = d1;
        r.ev = ev;  r.ewe = ewe; r.ea0 = ea0; r.ea1 = ea1;
        r.ed0 = ed0; r.ed1 = ed1; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t r);
        stall     = r.st;
        flush     = r.fl;
        mem_valid = r.v;
        mem_we    = r.we;
        mem_waddr = {r.a1, r.a0};
        mem_wdata = {r.d1, r.d0};
`ifdef MEM_WB_DEBUG_PC_EN
        mem_pc    = {r.d1 + 32'h100, r.d0 + 32'h100};
`endif
    endtask

    task automatic compare(input string tag, input vec_t e);
        check({tag, ".valid"}, 64'(wb_valid),   64'(e.ev));
        check({tag, ".we"},    64'(wb_we),      64'(e.ewe));
        check({tag, ".waddr"}, 64'(wb_waddr),   64'({e.ea1, e.ea0}));
        check({tag, ".wdata"}, wb_wdata,        {e.ed1, e.ed0});
        check({tag, ".cnt"},   64'(retire_cnt), 64'(e.ecnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, 64'(wb_valid),   64'd0);
        check({tag, ".we"},    64'(wb_we),      64'd0);
        check({tag, ".waddr"}, 64'(wb_waddr),   64'd0);
        check({tag, ".wdata"}, wb_wdata,        64'd0);
        check({tag, ".cnt"},   64'(retire_cnt), 64'd0);
    endtask

    initial begin
        vec_t e;
        checks = 0;
        errors = 0;

        //            st         fl  v      we     a0 a1 d0       d1        ev     ewe    ea0 ea1 ed0      ed1      cnt
        tbl[0]  = mk(6'b000000, 0, 2'b11, 2'b11, 3, 7, 32'h11,  32'h22,  2'b11, 2'b11, 3, 7, 32'h11,  32'h22,  4'd2);
        tbl[1]  = mk(6'b000000, 0, 2'b11, 2'b11, 5, 5, 32'hAA,  32'hBB,  2'b11, 2'b10, 5, 5, 32'hAA,  32'hBB,  4'd4);
        tbl[2]  = mk(6'b000000, 0, 2'b01, 2'b11, 0, 9, 32'h33,  32'h44,  2'b01, 2'b00, 0, 9, 32'h33,  32'h44,  4'd5);
        tbl[3]  = mk(6'b000000, 0, 2'b01, 2'b11, 6, 6, 32'h55,  32'h66,  2'b01, 2'b01, 6, 6, 32'h55,  32'h66,  4'd6);
        tbl[4]  = mk(6'b000000, 0, 2'b11, 2'b01, 8, 8, 32'h77,  32'h88,  2'b11, 2'b01, 8, 8, 32'h77,  32'h88,  4'd8);
        tbl[5]  = mk(6'b011111, 0, 2'b11, 2'b11, 1, 2, 32'h1,   32'h2,   2'b00, 2'b00, 0, 0, 32'h0,   32'h0,   4'd8);
        tbl[6]  = mk(6'b000000, 0, 2'b11, 2'b11, 1, 2, 32'h12,  32'h34,  2'b11, 2'b11, 1, 2, 32'h12,  32'h34,  4'd10);
        tbl[7]  = mk(6'b111111, 0, 2'b00, 2'b00, 9, 9, 32'hDE,  32'hAD,  2'b11, 2'b11, 1, 2, 32'h12,  32'h34,  4'd10);
        tbl[8]  = mk(6'b111111, 0, 2'b11, 2'b11, 4, 4, 32'hBE,  32'hEF,  2'b11, 2'b11, 1, 2, 32'h12,  32'h34,  4'd10);
        tbl[9]  = mk(6'b111111, 0, 2'b10, 2'b01, 0, 3, 32'h5A,  32'hA5,  2'b11, 2'b11, 1, 2, 32'h12,  32'h34,  4'd10);
        tbl[10] = mk(6'b111111, 1, 2'b11, 2'b11, 1, 2, 32'h9,   32'h9,   2'b00, 2'b00, 0, 0, 32'h0,   32'h0,   4'd10);
        tbl[11] = mk(6'b000000, 0, 2'b11, 2'b11, 3, 4, 32'hC0,  32'hC1,  2'b11, 2'b11, 3, 4, 32'hC0,  32'hC1,  4'd12);
        tbl[12] = mk(6'b000000, 1, 2'b11, 2'b11, 3, 4, 32'hC2,  32'hC3,  2'b00, 2'b00, 0, 0, 32'h0,   32'h0,   4'd12);
        tbl[13] = mk(6'b100000, 0, 2'b10, 2'b10, 0, 4, 32'h9,   32'hA,   2'b10, 2'b10, 0, 4, 32'h9,   32'hA,   4'd13);
        tbl[14] = mk(6'b000000, 0, 2'b01, 2'b01, 2, 0, 32'h1,   32'h2,   2'b01, 2'b01, 2, 0, 32'h1,   32'h2,   4'd14);
        tbl[15] = mk(6'b000000, 0, 2'b01, 2'b11, 0, 0, 32'h3,   32'h4,   2'b01, 2'b00, 0, 0, 32'h3,   32'h4,   4'd15);
        tbl[16] = mk(6'b000000, 0, 2'b01, 2'b01, 4, 1, 32'hF0,  32'hF1,  2'b01, 2'b01, 4, 1, 32'hF0,  32'hF1,  4'd0);
        tbl[17] = mk(6'b000000, 0, 2'b11, 2'b11, 2, 0, 32'h21,  32'h22,  2'b11, 2'b01, 2, 0, 32'h21,  32'h22,  4'd2);
        tbl[18] = mk(6'b000000, 0, 2'b11, 2'b11, 0, 0, 32'h31,  32'h32,  2'b11, 2'b00, 0, 0, 32'h31,  32'h32,  4'd4);

        rst = 1'b0;
        drive(mk(6'b0, 0, 2'b11, 2'b11, 3, 3, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: queue empty at vector %0d", i);
            end else begin
                e = exp_q.pop_front();
                compare($sformatf("vec%0d", i), e);
            end
        end

        // Async reset asserted mid-hold with outputs nonzero clears everything at once.
        drive(mk(6'b111111, 0, 2'b11, 2'b11, 7, 7, 32'h7, 32'h7, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid_stall");
        @(negedge clk);
        rst = 1'b1;
        drive(mk(6'b000000, 0, 2'b11, 2'b11, 3, 7, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 3, 7, 32'h11, 32'h22, 4'd2));
        @(negedge clk);
        e = exp_q.pop_front();
        compare("post_rst", e);

        // Async reset during a flush cycle.
        drive(mk(6'b000000, 1, 2'b11, 2'b11, 5, 6, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid_flush");
        @(negedge clk);
        rst = 1'b1;
        drive(mk(6'b000000, 0, 2'b10, 2'b10, 1, 6, 32'h50, 32'h60, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 6, 32'h50, 32'h60, 4'd1));
        @(negedge clk);
        e = exp_q.pop_front();
        compare("post_rst2", e);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
